// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_REG_W = 3;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Per-stage register controls, bundled so each decision is one assignment.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } pipe_ctl_t;

    // Build a control word: every enable set to en, both flushes set to fl.
    function automatic pipe_ctl_t ctl_uniform(input logic en, input logic fl);
        pipe_ctl_t c;
        c.pc_en      = en;
        c.ifid_en    = en;
        c.ifid_flush = fl;
        c.idex_en    = en;
        c.idex_flush = fl;
        c.exmem_en   = en;
        c.memwb_en   = en;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc until all-ones, then hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for the 5-stage core,
// load-use bubbles, redirect flushes, memory stalls and halt drain.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REG_W = DEF_REG_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_idex_dst,
    input  logic             i_idex_regwrite,
    input  logic             i_idex_memen,
    input  logic             i_idex_memwr,
    input  logic             i_ex_redirect,
    input  logic             i_mem_dump,
    input  logic             i_imem_stall,
    input  logic             i_dmem_stall,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t    r_state;
    state_t    w_state_nxt;
    pipe_ctl_t w_ctl;
    logic      w_halted;
    logic      w_load_use;
    logic      w_stall_inc;
    logic      w_flush_inc;

    // A load in EX whose destination feeds a source the decode stage actually reads.
    // r0 is deliberately not excluded: a match on it still bubbles.
    assign w_load_use = i_idex_memen & ~i_idex_memwr & i_idex_regwrite &
                        ((i_id_rs_used & (i_id_rs == i_idex_dst)) |
                         (i_id_rt_used & (i_id_rt == i_idex_dst)));

    // State register; reset always lands back in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-stage controls, highest-priority condition first.
    always_comb begin
        w_state_nxt = r_state;
        w_ctl       = ctl_uniform(1'b0, 1'b0);
        w_halted    = 1'b0;
        w_flush_inc = 1'b0;
        if (i_rst) begin
            // Hold everything and clear the stage registers while in reset.
            w_ctl       = ctl_uniform(1'b0, 1'b1);
            w_state_nxt = ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (i_dmem_stall) begin
                        // Whole pipe frozen; everything else re-evaluated later.
                        w_ctl = ctl_uniform(1'b0, 1'b0);
                    end else if (i_mem_dump) begin
                        // Let the dump instruction and older ones move on, freeze the front.
                        w_ctl.exmem_en = 1'b1;
                        w_ctl.memwb_en = 1'b1;
                        w_state_nxt    = ST_DRAIN;
                    end else if (i_ex_redirect) begin
                        // Wrong-path instructions in IF/ID and ID/EX are squashed.
                        w_ctl       = ctl_uniform(1'b1, 1'b1);
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        // Hold PC and IF/ID, inject one bubble into ID/EX.
                        w_ctl            = ctl_uniform(1'b1, 1'b0);
                        w_ctl.pc_en      = 1'b0;
                        w_ctl.ifid_en    = 1'b0;
                        w_ctl.idex_flush = 1'b1;
                    end else if (i_imem_stall) begin
                        // No fetch this cycle: feed a bubble into IF/ID, let the rest drain.
                        w_ctl            = ctl_uniform(1'b1, 1'b0);
                        w_ctl.pc_en      = 1'b0;
                        w_ctl.ifid_flush = 1'b1;
                    end else begin
                        w_ctl = ctl_uniform(1'b1, 1'b0);
                    end
                end
                ST_DRAIN: begin
                    // Final writeback of the dump instruction, then stop.
                    if (!i_dmem_stall) begin
                        w_ctl.memwb_en = 1'b1;
                        w_state_nxt    = ST_HALT;
                    end
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Only RUN-state stalls are counted; DRAIN/HALT idling is not a stall.
    assign w_stall_inc = ~i_rst & (r_state == ST_RUN) & ~w_ctl.pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_flush_inc),
        .o_count (o_flush_cnt)
    );

    assign o_pc_en      = w_ctl.pc_en;
    assign o_ifid_en    = w_ctl.ifid_en;
    assign o_ifid_flush = w_ctl.ifid_flush;
    assign o_idex_en    = w_ctl.idex_en;
    assign o_idex_flush = w_ctl.idex_flush;
    assign o_exmem_en   = w_ctl.exmem_en;
    assign o_memwb_en   = w_ctl.memwb_en;
    assign o_halted     = w_halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle decision table plus
// hand-written multi-cycle sequences (bubble release, dmem freeze, halt, saturation).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int REG_W = 3;

    // Expected output word order: {pc, ifid, ifid_fl, idex, idex_fl, exmem, memwb, halted}
    localparam logic [7:0] O_RUN   = 8'b11010110;
    localparam logic [7:0] O_LU    = 8'b00011110;
    localparam logic [7:0] O_REDIR = 8'b11111110;
    localparam logic [7:0] O_IMEM  = 8'b01110110;
    localparam logic [7:0] O_FROZE = 8'b00000000;
    localparam logic [7:0] O_DUMP  = 8'b00000110;
    localparam logic [7:0] O_DRAIN = 8'b00000010;
    localparam logic [7:0] O_HALT  = 8'b00000001;
    localparam logic [7:0] O_RST   = 8'b00101000;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, idex_dst;
    logic             id_rs_used, id_rt_used, idex_regwrite, idex_memen, idex_memwr;
    logic             ex_redirect, mem_dump, imem_stall, dmem_stall;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       outs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used),
        .i_idex_dst(idex_dst), .i_idex_regwrite(idex_regwrite), .i_idex_memen(idex_memen),
        .i_idex_memwr(idex_memwr), .i_ex_redirect(ex_redirect), .i_mem_dump(mem_dump),
        .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush), .o_idex_en(idex_en),
        .o_idex_flush(idex_flush), .o_exmem_en(exmem_en), .o_memwb_en(memwb_en),
        .o_halted(halted), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    typedef struct {
        string      name;
        logic [2:0] rs, rt, dst;
        logic       rs_used, rt_used, rw, men, mwr, redir, dump, imem, dmem;
        logic [7:0] exp;
        int         exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [2:0] rs, logic [2:0] rt, logic rs_used,
                                logic rt_used, logic [2:0] dst, logic rw, logic men, logic mwr,
                                logic redir, logic dump, logic imem, logic dmem,
                                logic [7:0] exp, int es, int ef);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.rs_used = rs_used; v.rt_used = rt_used;
        v.dst = dst; v.rw = rw; v.men = men; v.mwr = mwr; v.redir = redir; v.dump = dump;
        v.imem = imem; v.dmem = dmem; v.exp = exp; v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; idex_dst = '0;
        id_rs_used = 0; id_rt_used = 0; idex_regwrite = 0; idex_memen = 0; idex_memwr = 0;
        ex_redirect = 0; mem_dump = 0; imem_stall = 0; dmem_stall = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rs_used; id_rt_used = v.rt_used;
        idex_dst = v.dst; idex_regwrite = v.rw; idex_memen = v.men; idex_memwr = v.mwr;
        ex_redirect = v.redir; mem_dump = v.dump; imem_stall = v.imem; dmem_stall = v.dmem;
    endtask

    initial begin
        idle_inputs();
        rst = 1;

        //                name          rs rt ru tu dst rw me mw rd dp im dm  exp      st fl
        vecs.push_back(mk("idle",       1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("lu_rs",      3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, O_LU,    1, 0));
        vecs.push_back(mk("lu_rt",      1, 6, 0, 1, 6, 1, 1, 0, 0, 0, 0, 0, O_LU,    1, 0));
        vecs.push_back(mk("lu_r0",      0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_LU,    1, 0));
        vecs.push_back(mk("nolu_unused",3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("nolu_store", 3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("nolu_norw",  3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("nolu_alu",   3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("nolu_diff",  3, 5, 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, O_RUN,   0, 0));
        vecs.push_back(mk("redir_lu",   3, 0, 1, 0, 3, 1, 1, 0, 1, 0, 0, 0, O_REDIR, 0, 1));
        vecs.push_back(mk("redir_imem", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_REDIR, 0, 1));
        vecs.push_back(mk("lu_imem",    2, 0, 1, 0, 2, 1, 1, 0, 0, 0, 1, 0, O_LU,    1, 0));
        vecs.push_back(mk("imem",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IMEM,  1, 0));
        vecs.push_back(mk("dmem_redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_FROZE, 1, 0));
        vecs.push_back(mk("dmem_dump",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FROZE, 1, 0));
        vecs.push_back(mk("dump",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_DUMP,  1, 0));
        vecs.push_back(mk("dump_redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, O_DUMP,  1, 0));

        // Reset cycle outputs and cleared counters.
        @(negedge clk); #1;
        check("reset_outs", outs, O_RST);
        @(posedge clk); #1;
        rst = 0;
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);

        // Single-cycle decision table; each vector starts from a fresh reset.
        foreach (vecs[i]) begin
            do_reset();
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check({vecs[i].name, "_outs"}, outs, vecs[i].exp);
            @(posedge clk); #1;
            check({vecs[i].name, "_stall_cnt"}, stall_cnt, vecs[i].exp_stall);
            check({vecs[i].name, "_flush_cnt"}, flush_cnt, vecs[i].exp_flush);
        end

        // Load-use bubble is exactly one cycle: next cycle ID/EX holds a NOP.
        do_reset();
        @(negedge clk);
        id_rs = 3; id_rs_used = 1; idex_dst = 3; idex_regwrite = 1; idex_memen = 1;
        #1 check("lu_seq_bubble", outs, O_LU);
        @(negedge clk);
        idex_regwrite = 0; idex_memen = 0; idex_dst = 0;
        #1 check("lu_seq_release", outs, O_RUN);
        @(posedge clk); #1;
        check("lu_seq_stall_cnt", stall_cnt, 1);

        // dmem_stall held three cycles across a redirect, flush lands on cycle four.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_redirect = 1; dmem_stall = 1;
            #1 check($sformatf("dmem_hold_c%0d", c), outs, O_FROZE);
        end
        @(negedge clk);
        dmem_stall = 0;
        #1 check("dmem_release_redir", outs, O_REDIR);
        @(posedge clk); #1;
        check("dmem_seq_flush_cnt", flush_cnt, 1);
        check("dmem_seq_stall_cnt", stall_cnt, 3);

        // Dump -> DRAIN (with a dmem hold) -> HALT, then reset back to RUN.
        do_reset();
        @(negedge clk);
        mem_dump = 1;
        #1 check("halt_seq_dump", outs, O_DUMP);
        @(negedge clk);
        mem_dump = 0; ex_redirect = 1; dmem_stall = 1;
        #1 check("halt_seq_drain_dmem", outs, O_FROZE);
        @(negedge clk);
        dmem_stall = 0;
        #1 check("halt_seq_drain", outs, O_DRAIN);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check($sformatf("halt_seq_halt_c%0d", c), outs, O_HALT);
        end
        check("halt_seq_stall_cnt", stall_cnt, 1);
        check("halt_seq_flush_cnt", flush_cnt, 0);
        ex_redirect = 0;
        rst = 1;
        #1 check("halt_seq_rst_outs", outs, O_RST);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("halt_seq_rerun", outs, O_RUN);
        check("halt_seq_cnt_clr", stall_cnt, 0);

        // Reset in the middle of a stall clears the counter.
        do_reset();
        @(negedge clk);
        imem_stall = 1;
        repeat (2) @(posedge clk);
        #1 check("midstall_cnt", stall_cnt, 2);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; imem_stall = 0;
        check("midstall_rst_cnt", stall_cnt, 0);

        // Stall counter saturates at all-ones.
        do_reset();
        @(negedge clk);
        imem_stall = 1;
        repeat (15) @(posedge clk);
        #1 check("sat_at_max", stall_cnt, 15);
        repeat (5) @(posedge clk);
        #1 check("sat_hold", stall_cnt, 15);

        // Flush counter saturates too.
        do_reset();
        @(negedge clk);
        ex_redirect = 1;
        repeat (18) @(posedge clk);
        #1 check("flush_sat_hold", flush_cnt, 15);
        check("flush_sat_stall", stall_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
